// File: rtl/alu_mc_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle execute-stage ALU.
package alu_mc_pkg;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_SUB    = 5'h01,
    ALU_XOR    = 5'h02,
    ALU_OR     = 5'h03,
    ALU_AND    = 5'h04,
    ALU_SLT    = 5'h05,
    ALU_SRA    = 5'h06,
    ALU_SRL    = 5'h07,
    ALU_SLL    = 5'h08,
    ALU_NOP    = 5'h09,
    ALU_BNE    = 5'h0A,
    ALU_BLT    = 5'h0B,
    ALU_BGE    = 5'h0C,
    ALU_BEQ    = 5'h0D,
    ALU_LUI    = 5'h0E,
    ALU_JAL    = 5'h0F,
    ALU_SLTU   = 5'h10,
    ALU_MUL    = 5'h11,
    ALU_MULH   = 5'h12,
    ALU_MULHSU = 5'h13,
    ALU_MULHU  = 5'h14,
    ALU_DIV    = 5'h15,
    ALU_DIVU   = 5'h16,
    ALU_REM    = 5'h17,
    ALU_REMU   = 5'h18
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } md_state_e;

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle,
// working on operand magnitudes with the sign applied in a final FIX cycle.
module alu_mc_muldiv
  import alu_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [4:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  md_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]   hi_q, lo_q, opb_q, result_q;
  logic           is_mul_q, sel_hi_q, neg_q, done_q;

  alu_op_e        op_c;
  logic           a_signed_c, b_signed_c, a_neg_c, b_neg_c, b_zero_c;
  logic           is_mul_c, sel_hi_c, neg_c;
  logic [W-1:0]   a_mag_c, b_mag_c;

  // Operand decode: signedness, magnitudes and result sign at start
  always_comb begin
    op_c       = alu_op_e'(op_i);
    a_signed_c = 1'b0;
    b_signed_c = 1'b0;
    case (op_c)
      ALU_MULH:         begin a_signed_c = 1'b1; b_signed_c = 1'b1; end
      ALU_MULHSU:       a_signed_c = 1'b1;
      ALU_DIV, ALU_REM: begin a_signed_c = 1'b1; b_signed_c = 1'b1; end
      default:          ;
    endcase
    a_neg_c  = a_signed_c & a_i[W-1];
    b_neg_c  = b_signed_c & b_i[W-1];
    a_mag_c  = a_neg_c ? (~a_i + W'(1)) : a_i;
    b_mag_c  = b_neg_c ? (~b_i + W'(1)) : b_i;
    b_zero_c = (b_i == '0);
    is_mul_c = (op_c == ALU_MUL) || (op_c == ALU_MULH) ||
               (op_c == ALU_MULHSU) || (op_c == ALU_MULHU);
    sel_hi_c = is_mul_c ? (op_c != ALU_MUL) : ((op_c == ALU_REM) || (op_c == ALU_REMU));
    // A zero divisor must yield an all-ones quotient, so never negate it
    if (is_mul_c)      neg_c = a_neg_c ^ b_neg_c;
    else if (sel_hi_c) neg_c = a_neg_c;
    else               neg_c = (a_neg_c ^ b_neg_c) & ~b_zero_c;
  end

  logic [W:0]     add_c, shl_c;
  logic [W-1:0]   sub_c, hi_d, lo_d;
  logic           ge_c;

  // One multiply or divide step
  always_comb begin
    add_c = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    shl_c = {hi_q, lo_q[W-1]};
    ge_c  = (shl_c >= {1'b0, opb_q});
    sub_c = shl_c[W-1:0] - opb_q;
    if (is_mul_q) begin
      hi_d = add_c[W:1];
      lo_d = {add_c[0], lo_q[W-1:1]};
    end else begin
      hi_d = ge_c ? sub_c : shl_c[W-1:0];
      lo_d = {lo_q[W-2:0], ge_c};
    end
  end

  logic [2*W-1:0] prod_c, prod_fix_c;
  logic [W-1:0]   pick_c, fix_c;

  // Sign correction and hi/lo or quotient/remainder selection
  always_comb begin
    prod_c     = {hi_q, lo_q};
    prod_fix_c = neg_q ? (~prod_c + (2*W)'(1)) : prod_c;
    pick_c     = sel_hi_q ? hi_q : lo_q;
    if (is_mul_q) fix_c = sel_hi_q ? prod_fix_c[2*W-1:W] : prod_fix_c[W-1:0];
    else          fix_c = neg_q ? (~pick_c + W'(1)) : pick_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      is_mul_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            hi_q     <= '0;
            cnt_q    <= '0;
            is_mul_q <= is_mul_c;
            sel_hi_q <= sel_hi_c;
            neg_q    <= neg_c;
            opb_q    <= is_mul_c ? a_mag_c : b_mag_c;
            lo_q     <= is_mul_c ? b_mag_c : a_mag_c;
            state_q  <= is_mul_c ? ST_MUL : ST_DIV;
          end
        end
        ST_MUL, ST_DIV: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == CNT_W'(W-1)) state_q <= ST_FIX;
          else                      cnt_q   <= cnt_q + CNT_W'(1);
        end
        ST_FIX: begin
          result_q <= fix_c;
          done_q   <= 1'b1;
          cnt_q    <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU: single-cycle base ops plus iterative RV32M mul/div
// behind a valid/ready handshake with a registered result.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 5,
  parameter int unsigned PC_W          = 9,
  parameter int unsigned SHAMT_W       = $clog2(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     jalr,
  input  logic [PC_W-1:0]          Curr_Pc,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic [DATA_WIDTH-1:0]    jalr_src,
  output logic                     busy
);

  localparam int unsigned W = DATA_WIDTH;

  logic           in_ready_q, out_valid_q, busy_q;
  logic [W-1:0]   result_q, jalr_src_q;

  alu_op_e        op_c;
  logic           op_ok_c, is_md_c, accept_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic [PC_W-1:0]    pc_inc_c;
  logic [W-1:0]   sum_c, res_c, jalr_c;
  logic           md_done;
  logic [W-1:0]   md_result;

  // Single-cycle datapath and mul/div dispatch decode
  always_comb begin
    op_ok_c  = (32'(Operation) < 32'd32);
    op_c     = alu_op_e'(Operation[4:0]);
    is_md_c  = op_ok_c && (op_c >= ALU_MUL) && (op_c <= ALU_REMU);
    accept_c = in_valid & in_ready_q;
    shamt_c  = SrcB[SHAMT_W-1:0];
    pc_inc_c = Curr_Pc + PC_W'(PC_INC);
    sum_c    = SrcA + SrcB;
    res_c    = '0;
    jalr_c   = '0;
    if (op_ok_c) begin
      case (op_c)
        ALU_ADD:  res_c = sum_c;
        ALU_SUB:  res_c = SrcA - SrcB;
        ALU_XOR:  res_c = SrcA ^ SrcB;
        ALU_OR:   res_c = SrcA | SrcB;
        ALU_AND:  res_c = SrcA & SrcB;
        ALU_SLT:  res_c = W'($signed(SrcA) < $signed(SrcB));
        ALU_SRA:  res_c = $unsigned($signed(SrcA) >>> shamt_c);
        ALU_SRL:  res_c = SrcA >> shamt_c;
        ALU_SLL:  res_c = SrcA << shamt_c;
        ALU_BNE:  res_c = W'(SrcA != SrcB);
        ALU_BLT:  res_c = W'($signed(SrcA) < $signed(SrcB));
        ALU_BGE:  res_c = W'($signed(SrcA) >= $signed(SrcB));
        ALU_BEQ:  res_c = W'(SrcA == SrcB);
        ALU_LUI:  res_c = SrcB;
        ALU_JAL: begin
          res_c  = W'(pc_inc_c);
          jalr_c = jalr ? {sum_c[W-1:1], 1'b0} : '0;
        end
        ALU_SLTU: res_c = W'(SrcA < SrcB);
        default:  res_c = '0;
      endcase
    end
  end

  alu_mc_muldiv #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept_c & is_md_c),
    .op_i     (Operation[4:0]),
    .a_i      (SrcA),
    .b_i      (SrcB),
    .done_o   (md_done),
    .result_o (md_result)
  );

  // Handshake and result registers; mul/div holds off new work until done
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      jalr_src_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (md_done) begin
        result_q    <= md_result;
        jalr_src_q  <= '0;
        out_valid_q <= 1'b1;
        in_ready_q  <= 1'b1;
        busy_q      <= 1'b0;
      end else if (accept_c) begin
        if (is_md_c) begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end else begin
          result_q    <= res_c;
          jalr_src_q  <= jalr_c;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign ALUResult = result_q;
  assign jalr_src  = jalr_src_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: expected results queued at issue, checked on out_valid.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, jalr, out_valid, busy;
  logic [W-1:0]  SrcA, SrcB, ALUResult, jalr_src;
  logic [4:0]    Operation;
  logic [8:0]    Curr_Pc;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] jsrc;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_mc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .jalr      (jalr),
    .Curr_Pc   (Curr_Pc),
    .out_valid (out_valid),
    .ALUResult (ALUResult),
    .jalr_src  (jalr_src),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending result
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && out_valid === 1'b1) begin
      n_checks++;
      assert (sb.size() != 0)
      else begin
        n_fail++;
        $error("FAIL spurious_out_valid: observed out_valid=1 result %h expected no pending result", ALUResult);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, "_res"}, ALUResult, e.res);
        check({e.tag, "_jsrc"}, jalr_src, e.jsrc);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [8:0] pc, input logic jr, input logic [W-1:0] er,
                       input logic [W-1:0] ej, input bit push, input string tag);
    exp_t e;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    Curr_Pc   = pc;
    jalr      = jr;
    in_valid  = 1'b1;
    if (push) begin
      e.res  = er;
      e.jsrc = ej;
      e.tag  = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int i;
    i = 0;
    while (sb.size() != 0 && i < max_cyc) begin
      @(posedge clk);
      #1;
      i++;
    end
    check({tag, "_drain"}, W'(sb.size()), '0);
  endtask

  initial begin
    int n;
    int ov_seen;
    bit hold_ok;

    reset     = 1'b1;
    in_valid  = 1'b0;
    SrcA      = '0;
    SrcB      = '0;
    Operation = '0;
    jalr      = 1'b0;
    Curr_Pc   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_busy",      W'(busy),      '0);
    check("rst_result",    ALUResult,     '0);
    check("rst_jalr_src",  jalr_src,      '0);
    reset = 1'b0;

    // Back-to-back single-cycle ops
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 9'h0, 1'b0, 32'h8000_0000, '0, 1'b1, "add_wrap");
    check("add_ov", W'(out_valid), W'(1));
    issue(ALU_SUB, 32'd5, 32'd7, 9'h0, 1'b0, 32'hFFFF_FFFE, '0, 1'b1, "sub_neg");
    check("sub_ov", W'(out_valid), W'(1));
    issue(ALU_SRA,  32'h8000_0000, 32'd4,  9'h0, 1'b0, 32'hF800_0000, '0, 1'b1, "sra");
    issue(ALU_SRL,  32'h8000_0000, 32'd4,  9'h0, 1'b0, 32'h0800_0000, '0, 1'b1, "srl");
    issue(ALU_SLL,  32'h1, 32'h21,         9'h0, 1'b0, 32'h0000_0002, '0, 1'b1, "sll_mask");
    issue(ALU_SLT,  32'h8000_0000, 32'h1,  9'h0, 1'b0, 32'h1, '0, 1'b1, "slt");
    issue(ALU_SLTU, 32'h8000_0000, 32'h1,  9'h0, 1'b0, 32'h0, '0, 1'b1, "sltu");
    issue(ALU_XOR,  32'hF0F0, 32'hFF00,    9'h0, 1'b0, 32'h0FF0, '0, 1'b1, "xor");
    issue(ALU_AND,  32'hF0F0, 32'hFF00,    9'h0, 1'b0, 32'hF000, '0, 1'b1, "and");
    issue(ALU_OR,   32'hF0F0, 32'hFF00,    9'h0, 1'b0, 32'hFFF0, '0, 1'b1, "or");
    issue(ALU_BNE,  32'd3, 32'd3,          9'h0, 1'b0, 32'h0, '0, 1'b1, "bne");
    issue(ALU_BEQ,  32'd3, 32'd3,          9'h0, 1'b0, 32'h1, '0, 1'b1, "beq");
    issue(ALU_BLT,  32'hFFFF_FFFF, 32'h0,  9'h0, 1'b0, 32'h1, '0, 1'b1, "blt");
    issue(ALU_BGE,  32'hFFFF_FFFF, 32'h0,  9'h0, 1'b0, 32'h0, '0, 1'b1, "bge");
    issue(ALU_LUI,  32'hDEAD, 32'h1234_5000, 9'h0, 1'b0, 32'h1234_5000, '0, 1'b1, "lui");
    issue(ALU_NOP,  32'd5, 32'd5,          9'h0, 1'b0, 32'h0, '0, 1'b1, "nop");
    issue(ALU_JAL,  32'h101, 32'h2,      9'h1FC, 1'b1, 32'h0, 32'h102, 1'b1, "jalr_wrap");
    issue(ALU_JAL,  32'h101, 32'h2,      9'h010, 1'b0, 32'h14, 32'h0, 1'b1, "jal");
    issue(5'h1F,    32'd5, 32'd5,          9'h0, 1'b0, 32'h0, '0, 1'b1, "undef_op");
    drain("single", 5);

    // MULH latency, in_ready held low, in_valid during busy ignored
    issue(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 9'h0, 1'b0, 32'h4000_0000, '0, 1'b1, "mulh");
    n       = 0;
    hold_ok = 1'b1;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
      if (n == 5) begin
        Operation = ALU_ADD;
        SrcA      = 32'd1;
        SrcB      = 32'd1;
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("mulh_latency",    W'(n),        W'(34));
    check("mulh_hold_busy",  W'(hold_ok),  W'(1));
    check("mulh_ready_back", W'(in_ready), W'(1));
    drain("mulh", 5);

    issue(ALU_MUL,    32'hFFFF_FFFF, 32'd3,         9'h0, 1'b0, 32'hFFFF_FFFD, '0, 1'b1, "mul");
    drain("mul", 40);
    issue(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 9'h0, 1'b0, 32'hFFFF_FFFE, '0, 1'b1, "mulhu");
    drain("mulhu", 40);
    issue(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9'h0, 1'b0, 32'hFFFF_FFFF, '0, 1'b1, "mulhsu");
    drain("mulhsu", 40);
    issue(ALU_DIV,    32'd7, 32'd0,                 9'h0, 1'b0, 32'hFFFF_FFFF, '0, 1'b1, "div_by0");
    drain("div_by0", 40);
    issue(ALU_REM,    32'd7, 32'd0,                 9'h0, 1'b0, 32'd7, '0, 1'b1, "rem_by0");
    drain("rem_by0", 40);
    issue(ALU_REM,    32'hFFFF_FFF9, 32'd0,         9'h0, 1'b0, 32'hFFFF_FFF9, '0, 1'b1, "rem_neg_by0");
    drain("rem_neg_by0", 40);
    issue(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 9'h0, 1'b0, 32'h8000_0000, '0, 1'b1, "div_ovf");
    drain("div_ovf", 40);
    issue(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 9'h0, 1'b0, 32'h0, '0, 1'b1, "rem_ovf");
    drain("rem_ovf", 40);
    issue(ALU_DIV,    32'hFFFF_FFF9, 32'd2,         9'h0, 1'b0, 32'hFFFF_FFFD, '0, 1'b1, "div_neg");
    drain("div_neg", 40);
    issue(ALU_REM,    32'hFFFF_FFF9, 32'd2,         9'h0, 1'b0, 32'hFFFF_FFFF, '0, 1'b1, "rem_neg");
    drain("rem_neg", 40);
    issue(ALU_DIVU,   32'd100, 32'd7,               9'h0, 1'b0, 32'd14, '0, 1'b1, "divu");
    drain("divu", 40);
    issue(ALU_REMU,   32'd100, 32'd7,               9'h0, 1'b0, 32'd2, '0, 1'b1, "remu");
    drain("remu", 40);

    // Reset in the middle of a DIVU aborts it
    issue(ALU_DIVU, 32'd100, 32'd7, 9'h0, 1'b0, '0, '0, 1'b0, "divu_abort");
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready",  W'(in_ready),  W'(1));
    check("abort_busy",      W'(busy),      '0);
    check("abort_out_valid", W'(out_valid), '0);
    check("abort_result",    ALUResult,     '0);
    reset   = 1'b0;
    ov_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) ov_seen++;
    end
    check("abort_no_ov", W'(ov_seen), '0);
    issue(ALU_ADD, 32'd2, 32'd3, 9'h0, 1'b0, 32'd5, '0, 1'b1, "add_after_rst");
    check("add_after_rst_ov", W'(out_valid), W'(1));
    drain("final", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
